// File: rtl/prio_encode_4to2_pkg.sv
// Shared constants and FSM state type for the 4-to-2 priority encoder.
// Imported by the interface, the picker and the top (macro: ENCODE_ROUND_ROBIN_EN).
package encode_pkg;

    localparam int NUM_REQ = 4;
    localparam int CODE_W  = 2;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [NUM_REQ-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/prio_encode_4to2_if.sv
// Request/grant bus of prio_encode_4to2: request lines, disable, and the
// valid/ready code output. The master side drives requests, the slave is the encoder.
interface prio_encode_4to2_if;

    logic                                e;
    logic [encode_pkg::NUM_REQ-1:0]      req_in;
    logic                                ready_in;
    logic [encode_pkg::CODE_W-1:0]       code_out;
    logic                                valid_out;
    logic [encode_pkg::NUM_REQ-1:0]      pend_out;

    modport master (
        output e,
        output req_in,
        output ready_in,
        input  code_out,
        input  valid_out,
        input  pend_out
    );

    modport slave (
        input  e,
        input  req_in,
        input  ready_in,
        output code_out,
        output valid_out,
        output pend_out
    );

endinterface

// File: rtl/prio_encode_4to2_prio_pick4.sv
// Combinational picker: searches pend in the order start-1, start-2, start-3, start
// (mod 4); start=0 gives fixed priority 3 > 2 > 1 > 0.
module prio_pick4
    import encode_pkg::*;
(
    input  logic [NUM_REQ-1:0] pend,
    input  logic [CODE_W-1:0]  start,
    output logic [CODE_W-1:0]  idx,
    output logic               any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any && pend[start - CODE_W'(i)]) begin
                idx = start - CODE_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encode_4to2.sv
// Sequential 4-to-2 priority encoder with sticky pending register and valid/ready output.
// Define ENCODE_ROUND_ROBIN_EN for round-robin selection starting from RR_START.
module prio_encode_4to2
    import encode_pkg::*;
#(
    parameter logic [CODE_W-1:0] RR_START = '0
) (
    input  logic                clk,
    input  logic                rst,
    prio_encode_4to2_if.slave   bus
);

    state_t             state;
    logic [NUM_REQ-1:0] pend;
    logic [CODE_W-1:0]  code_reg;
    logic               valid_reg;
    logic [CODE_W-1:0]  start;
    logic [CODE_W-1:0]  pick_idx;
    logic               pick_any;
    logic               handshake;
    logic [NUM_REQ-1:0] clr;

    assign handshake = valid_reg & bus.ready_in;
    assign clr       = handshake ? onehot(code_reg) : '0;

`ifdef ENCODE_ROUND_ROBIN_EN
    logic [CODE_W-1:0] last;

    always_ff @(posedge clk) begin
        if (rst || bus.e) begin
            last <= RR_START;
        end else if (handshake) begin
            last <= code_reg;
        end
    end

    assign start = last;
`else
    // Fixed priority is the search anchored at 0; the start parameter has no effect here.
    assign start = RR_START & '0;
`endif

    prio_pick4 u_pick (
        .pend  (pend),
        .start (start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Selection looks at the registered pend, so a request takes two edges to reach valid.
    always_ff @(posedge clk) begin
        if (rst || bus.e) begin
            pend      <= '0;
            state     <= IDLE;
            code_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            pend <= (pend & ~clr) | bus.req_in;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        code_reg  <= pick_idx;
                        valid_reg <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ready_in) begin
                        valid_reg <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.code_out  = code_reg;
    assign bus.valid_out = valid_reg;
    assign bus.pend_out  = pend;

endmodule

// File: tb/tb_prio_encode_4to2.sv
// Self-checking bench for prio_encode_4to2: expected grants are queued when requests
// are driven and popped on each observed handshake; works with or without ENCODE_ROUND_ROBIN_EN.
module tb_prio_encode_4to2;

    logic clk;
    logic rst;

    prio_encode_4to2_if bus();

    prio_encode_4to2 #(.RR_START(2'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared;
    int mismatched;
    int exp_q[$];
    int exp_code;
    int cyc;
    int last_grant;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.e        = 1'b0;
        bus.req_in   = 4'b0000;
        bus.ready_in = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_in = 4'b1111;
        step();
        do_reset();
        compared++;
        if (bus.valid_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_valid: got %b want 0", bus.valid_out);
        end
        compared++;
        if (bus.code_out !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_code: got %0d want 0", bus.code_out);
        end
        compared++;
        if (bus.pend_out !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_pend: got %b want 0000", bus.pend_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        exp_q.push_back(2);
        bus.ready_in = 1'b1;
        bus.req_in   = 4'b0100;
        step();
        bus.req_in = 4'b0000;
        compared++;
        if (bus.pend_out !== 4'b0100 || bus.valid_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_latency1: pend %b valid %b want 0100/0", bus.pend_out, bus.valid_out);
        end
        step();
        compared++;
        if (bus.valid_out !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_valid: got %b want 1", bus.valid_out);
        end
        exp_code = exp_q.pop_front();
        compared++;
        if (bus.code_out !== exp_code[1:0]) begin
            mismatched++;
            $display("[TB] FAIL single_code: got %0d want %0d", bus.code_out, exp_code);
        end
        step();
        compared++;
        if (bus.valid_out !== 1'b0 || bus.pend_out !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL single_after: valid %b pend %b want 0/0000", bus.valid_out, bus.pend_out);
        end
    endtask

    task automatic test_multi();
        do_reset();
        exp_q.push_back(3);
        exp_q.push_back(1);
        exp_q.push_back(0);
        bus.ready_in = 1'b1;
        bus.req_in   = 4'b1011;
        step();
        bus.req_in = 4'b0000;
        cyc        = 0;
        last_grant = -1;
        while (exp_q.size() > 0 && cyc < 40) begin
            if (bus.valid_out && bus.ready_in) begin
                exp_code = exp_q.pop_front();
                compared++;
                if (bus.code_out !== exp_code[1:0]) begin
                    mismatched++;
                    $display("[TB] FAIL multi_code: got %0d want %0d", bus.code_out, exp_code);
                end
                if (last_grant >= 0) begin
                    compared++;
                    if (cyc - last_grant != 2) begin
                        mismatched++;
                        $display("[TB] FAIL multi_spacing: got %0d cycles want 2", cyc - last_grant);
                    end
                end
                last_grant = cyc;
            end
            step();
            cyc++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL multi_timeout: %0d grants missing want 0", exp_q.size());
            exp_q.delete();
        end
        step();
        compared++;
        if (bus.valid_out !== 1'b0 || bus.pend_out !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL multi_idle: valid %b pend %b want 0/0000", bus.valid_out, bus.pend_out);
        end
    endtask

    task automatic test_stall();
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(3);
        bus.req_in = 4'b0001;
        step();
        bus.req_in = 4'b0000;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.req_in = (i == 1) ? 4'b1000 : 4'b0000;
            step();
            compared++;
            if (bus.valid_out !== 1'b1 || bus.code_out !== 2'd0) begin
                mismatched++;
                $display("[TB] FAIL stall_hold: valid %b code %0d want 1/0", bus.valid_out, bus.code_out);
            end
        end
        bus.req_in = 4'b0000;
        compared++;
        if (bus.pend_out !== 4'b1001) begin
            mismatched++;
            $display("[TB] FAIL stall_pend: got %b want 1001", bus.pend_out);
        end
        bus.ready_in = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            if (bus.valid_out && bus.ready_in) begin
                exp_code = exp_q.pop_front();
                compared++;
                if (bus.code_out !== exp_code[1:0]) begin
                    mismatched++;
                    $display("[TB] FAIL stall_code: got %0d want %0d", bus.code_out, exp_code);
                end
            end
            step();
            cyc++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL stall_timeout: %0d grants missing want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        exp_q.push_back(2);
        exp_q.push_back(2);
        bus.req_in = 4'b0100;
        step();
        bus.req_in = 4'b0000;
        step();
        bus.ready_in = 1'b1;
        bus.req_in   = 4'b0100;
        exp_code = exp_q.pop_front();
        compared++;
        if (bus.valid_out !== 1'b1 || bus.code_out !== exp_code[1:0]) begin
            mismatched++;
            $display("[TB] FAIL setwins_first: valid %b code %0d want 1/%0d", bus.valid_out, bus.code_out, exp_code);
        end
        step();
        bus.req_in = 4'b0000;
        compared++;
        if (bus.pend_out !== 4'b0100 || bus.valid_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL setwins_pend: pend %b valid %b want 0100/0", bus.pend_out, bus.valid_out);
        end
        step();
        exp_code = exp_q.pop_front();
        compared++;
        if (bus.valid_out !== 1'b1 || bus.code_out !== exp_code[1:0]) begin
            mismatched++;
            $display("[TB] FAIL setwins_again: valid %b code %0d want 1/%0d", bus.valid_out, bus.code_out, exp_code);
        end
        step();
        compared++;
        if (bus.valid_out !== 1'b0 || bus.pend_out !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL setwins_idle: valid %b pend %b want 0/0000", bus.valid_out, bus.pend_out);
        end
    endtask

    task automatic test_disable();
        do_reset();
        bus.req_in = 4'b1111;
        step();
        bus.req_in = 4'b0000;
        step();
        compared++;
        if (bus.valid_out !== 1'b1 || bus.code_out !== 2'd3 || bus.pend_out !== 4'b1111) begin
            mismatched++;
            $display("[TB] FAIL disable_setup: valid %b code %0d pend %b want 1/3/1111",
                     bus.valid_out, bus.code_out, bus.pend_out);
        end
        // Disable lands on a would-be handshake edge.
        bus.e        = 1'b1;
        bus.ready_in = 1'b1;
        step();
        compared++;
        if (bus.valid_out !== 1'b0 || bus.pend_out !== 4'b0000 || bus.code_out !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL disable_clear: valid %b code %0d pend %b want 0/0/0000",
                     bus.valid_out, bus.code_out, bus.pend_out);
        end
        for (int i = 0; i < 3; i++) begin
            bus.req_in = 4'b1111;
            step();
            compared++;
            if (bus.valid_out !== 1'b0 || bus.pend_out !== 4'b0000) begin
                mismatched++;
                $display("[TB] FAIL disable_ignore: valid %b pend %b want 0/0000", bus.valid_out, bus.pend_out);
            end
        end
        bus.req_in = 4'b0000;
        bus.e      = 1'b0;
        step();
        step();
        compared++;
        if (bus.valid_out !== 1'b0 || bus.pend_out !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL disable_after: valid %b pend %b want 0/0000", bus.valid_out, bus.pend_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
`ifdef ENCODE_ROUND_ROBIN_EN
        for (int i = 0; i < 6; i++) exp_q.push_back(3 - (i % 4));
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(3);
`endif
        bus.ready_in = 1'b1;
        bus.req_in   = 4'b1111;
        cyc        = 0;
        last_grant = -1;
        while (exp_q.size() > 0 && cyc < 60) begin
            if (bus.valid_out && bus.ready_in) begin
                exp_code = exp_q.pop_front();
                compared++;
                if (bus.code_out !== exp_code[1:0]) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_code: got %0d want %0d", bus.code_out, exp_code);
                end
                if (last_grant >= 0) begin
                    compared++;
                    if (cyc - last_grant != 2) begin
                        mismatched++;
                        $display("[TB] FAIL b2b_spacing: got %0d cycles want 2", cyc - last_grant);
                    end
                end
                last_grant = cyc;
            end
            step();
            cyc++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_timeout: %0d grants missing want 0", exp_q.size());
            exp_q.delete();
        end
        bus.req_in = 4'b0000;
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst          = 1'b1;
        bus.e        = 1'b0;
        bus.req_in   = 4'b0000;
        bus.ready_in = 1'b0;
        step();
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_set_wins();
        test_disable();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
